mem_req_ctrl: RTL and testbench
===============================

Name: mem_req_ctrl

Overview:
- Sits between the pipeline memory stage and mem_system.
- Accepts one load or store at a time from the pipeline and freezes the pipeline while the access is in flight.
- Drives Addr/DataIn/Rd/Wr stably into mem_system until Done, then returns load data.
- Counts cache hits and misses and traps protocol, alignment and timeout errors.

Parameters:
TIMEOUT, 64, max cycles from issue to Done before declaring error (>=2)
CNT_W, 16, width of hit/miss counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_rd  in  1  pipeline load request
req_wr  in  1  pipeline store request
req_addr  in  16  byte address
req_data  in  16  store data
stall_pipe  out  1  freeze pipeline (combinational)
rsp_valid  out  1  one-cycle pulse: access complete
rsp_data  out  16  load data, valid with rsp_valid, held until next load completes
Addr  out  16  to mem_system
DataIn  out  16  to mem_system
Rd  out  1  to mem_system
Wr  out  1  to mem_system
DataOut  in  16  from mem_system
Done  in  1  from mem_system, one-cycle completion pulse
Stall  in  1  from mem_system (informational only)
CacheHit  in  1  from mem_system, qualified by Done
mem_err  in  1  from mem_system error
err  out  1  sticky error
hit_cnt  out  CNT_W  completed accesses with CacheHit=1
miss_cnt  out  CNT_W  completed accesses with CacheHit=0

Behaviour:
- Reset (rst=0, async): state IDLE; Addr, DataIn, rsp_data, and both counters = 0; Rd, Wr, rsp_valid and err = 0. Reset mid-access abandons the access immediately; no rsp_valid is produced.
- States: IDLE, ISSUE, RESP, ERR.
- IDLE:
  - req_rd & req_wr -> ERR.
  - Exactly one of req_rd/req_wr with req_addr[0]=1 (misaligned) -> ERR; nothing is issued.
  - Otherwise latch addr/data/type into Addr/DataIn/Rd or Wr -> ISSUE; timeout counter cleared.
- ISSUE:
  - Rd/Wr, Addr and DataIn held constant every cycle.
  - Timeout counter increments each cycle.
  - Done=1 -> RESP. On that edge: rsp_data <= DataOut if a load (unchanged for a store); hit_cnt or miss_cnt +1 per CacheHit, saturating at all-ones; Rd and Wr cleared.
  - mem_err=1 or counter reaching TIMEOUT without Done -> ERR. If mem_err and Done occur in the same cycle, mem_err wins.
- RESP:
  - rsp_valid=1 for exactly this one cycle -> IDLE.
  - A new request is not accepted in this cycle.
- ERR:
  - err=1, sticky until reset; Rd=Wr=0; stall_pipe=1; no further requests accepted.
- stall_pipe = (state==ISSUE) | (state==ERR) | (state==IDLE & (req_rd|req_wr)). It is 0 in RESP, so the pipeline advances on the rsp_valid cycle.
- Latency: request seen at edge k; Rd/Wr visible after k; Done sampled at edge d; rsp_valid high during cycle d+1. Minimum is 3 cycles from request to rsp_valid (1-cycle Done).
- Done seen in IDLE or RESP (spurious) -> ERR.
- Pipeline must hold req_* stable while stall_pipe=1. Request inputs are ignored outside IDLE.
- Back-to-back requests: the next request is accepted in the IDLE cycle following RESP, so the minimum spacing between issues is 3 cycles.

Test Plan:
- Load hit: req_rd, addr 0x0010; model Done+CacheHit 1 cycle after issue with DataOut 0xBEEF -> Rd held 1 cycle, rsp_data=0xBEEF with rsp_valid one cycle later, hit_cnt=1, stall_pipe low on the rsp_valid cycle.
- Store miss: req_wr, addr 0x0200, data 0x1234; Done after 12 cycles with CacheHit=0 -> Addr/DataIn/Wr stable all 12 cycles, miss_cnt=1, rsp_data unchanged.
- Errors from IDLE: req_rd=req_wr=1 -> err next cycle, Rd=Wr=0. After reset, req_rd with addr 0x0003 -> err, Rd never asserted.
- Timeout: TIMEOUT=8, Done never asserted -> err rises on the 8th ISSUE cycle. Separately, mem_err pulse during ISSUE -> err, sticky through 20 further cycles.
- Reset mid-access: rst low 3 cycles into ISSUE -> all outputs 0 asynchronously. After release, a new load completes normally with counters starting at 0.
- Counter saturation: CNT_W=2, 5 hit accesses -> hit_cnt sequence 1,2,3,3,3. Back-to-back loads show issue spacing of exactly 3 cycles.

Source files
------------

// File: rtl/mem_req_ctrl_if.sv
// Bundle of pipeline-side and mem_system-side signals around mem_req_ctrl.
// The controller connects through the slave modport; the environment drives it via master.
interface mem_req_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             req_rd;
  logic             req_wr;
  logic [15:0]      req_addr;
  logic [15:0]      req_data;
  logic             stall_pipe;
  logic             rsp_valid;
  logic [15:0]      rsp_data;
  logic [15:0]      Addr;
  logic [15:0]      DataIn;
  logic             Rd;
  logic             Wr;
  logic [15:0]      DataOut;
  logic             Done;
  logic             Stall;
  logic             CacheHit;
  logic             mem_err;
  logic             err;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output req_rd, req_wr, req_addr, req_data,
    output DataOut, Done, Stall, CacheHit, mem_err,
    input  stall_pipe, rsp_valid, rsp_data,
    input  Addr, DataIn, Rd, Wr,
    input  err, hit_cnt, miss_cnt
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_data,
    input  DataOut, Done, Stall, CacheHit, mem_err,
    output stall_pipe, rsp_valid, rsp_data,
    output Addr, DataIn, Rd, Wr,
    output err, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Single-outstanding memory request controller between the pipeline memory stage
// and mem_system: issues one access, freezes the pipeline, returns data, counts hits/misses.
module mem_req_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           rst,
  mem_req_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    ERR   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic             req_any_s;
  logic             req_bad_s;
  logic             tmo_last_s;
  logic             stall_pipe_s;
  logic             rsp_valid_s;
  logic             err_s;
  logic             unused_stall_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1'b1);
    end
  endfunction

  assign req_any_s  = bus.req_rd | bus.req_wr;
  // Conflicting type or odd byte address is refused before anything reaches mem_system.
  assign req_bad_s  = (bus.req_rd & bus.req_wr) | (req_any_s & bus.req_addr[0]);
  assign tmo_last_s = (tmo_q == TW'(TIMEOUT - 1));

  // Mem_system stall is informational; the controller only reacts to Done.
  assign unused_stall_s = bus.Stall;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; mem_err outranks Done, and Done outranks the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.Done) begin
          state_d = ERR;
        end else if (req_bad_s) begin
          state_d = ERR;
        end else if (req_any_s) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_err) begin
          state_d = ERR;
        end else if (bus.Done) begin
          state_d = RESP;
        end else if (tmo_last_s) begin
          state_d = ERR;
        end else begin
          state_d = ISSUE;
        end
      end
      RESP: begin
        if (bus.Done) begin
          state_d = ERR;
        end else begin
          state_d = IDLE;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // FSM output decode; stall drops in RESP so the pipeline advances with rsp_valid.
  always_comb begin
    rsp_valid_s  = 1'b0;
    err_s        = 1'b0;
    stall_pipe_s = 1'b0;
    case (state_q)
      IDLE:    stall_pipe_s = req_any_s;
      ISSUE:   stall_pipe_s = 1'b1;
      RESP:    rsp_valid_s  = 1'b1;
      ERR: begin
        err_s        = 1'b1;
        stall_pipe_s = 1'b1;
      end
      default: begin
        err_s        = 1'b1;
        stall_pipe_s = 1'b1;
      end
    endcase
  end

  // Datapath next-state: latch request on issue, capture response and counters on Done.
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    tmo_d      = tmo_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    case (state_q)
      IDLE: begin
        if (state_d == ISSUE) begin
          addr_d = bus.req_addr;
          data_d = bus.req_data;
          rd_d   = bus.req_rd;
          wr_d   = bus.req_wr;
          tmo_d  = {TW{1'b0}};
        end else begin
          rd_d   = 1'b0;
          wr_d   = 1'b0;
        end
      end
      ISSUE: begin
        tmo_d = tmo_q + TW'(1'b1);
        if (state_d == RESP) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (rd_q) begin
            rsp_data_d = bus.DataOut;
          end else begin
            rsp_data_d = rsp_data_q;
          end
          if (bus.CacheHit) begin
            hit_d = sat_inc(hit_q);
          end else begin
            miss_d = sat_inc(miss_q);
          end
        end else if (state_d == ERR) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
        end else begin
          rd_d = rd_q;
          wr_d = wr_q;
        end
      end
      RESP: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
      ERR: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
      default: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
      rsp_data_q <= 16'h0000;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      tmo_q      <= {TW{1'b0}};
      hit_q      <= {CNT_W{1'b0}};
      miss_q     <= {CNT_W{1'b0}};
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      tmo_q      <= tmo_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  assign bus.Addr       = addr_q;
  assign bus.DataIn     = data_q;
  assign bus.Rd         = rd_q;
  assign bus.Wr         = wr_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_valid  = rsp_valid_s;
  assign bus.err        = err_s;
  assign bus.stall_pipe = stall_pipe_s;
  assign bus.hit_cnt    = hit_q;
  assign bus.miss_cnt   = miss_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: dut_a uses defaults, dut_b uses TIMEOUT=8/CNT_W=2;
// both see identical stimulus.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd, req_wr, done, cache_hit, mem_err, stall;
  logic [15:0] req_addr, req_data, data_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  mem_req_ctrl_if #(.CNT_W(16)) bus_a ();
  mem_req_ctrl_if #(.CNT_W(2))  bus_b ();

  assign bus_a.req_rd   = req_rd;
  assign bus_a.req_wr   = req_wr;
  assign bus_a.req_addr = req_addr;
  assign bus_a.req_data = req_data;
  assign bus_a.DataOut  = data_out;
  assign bus_a.Done     = done;
  assign bus_a.Stall    = stall;
  assign bus_a.CacheHit = cache_hit;
  assign bus_a.mem_err  = mem_err;

  assign bus_b.req_rd   = req_rd;
  assign bus_b.req_wr   = req_wr;
  assign bus_b.req_addr = req_addr;
  assign bus_b.req_data = req_data;
  assign bus_b.DataOut  = data_out;
  assign bus_b.Done     = done;
  assign bus_b.Stall    = stall;
  assign bus_b.CacheHit = cache_hit;
  assign bus_b.mem_err  = mem_err;

  mem_req_ctrl #(.TIMEOUT(64), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_req_ctrl #(.TIMEOUT(8),  .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    req_rd    = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 16'h0000;
    req_data  = 16'h0000;
    data_out  = 16'h0000;
    done      = 1'b0;
    cache_hit = 1'b0;
    mem_err   = 1'b0;
    stall     = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // One complete load hit on dut_a with a 1-cycle Done.
  task automatic do_load_hit(input logic [15:0] addr, input logic [15:0] dout,
                             input logic [15:0] exp_hits);
    req_rd   = 1'b1;
    req_addr = addr;
    step();
    check_eq("ld_issue", {bus_a.Rd, bus_a.Addr}, {1'b1, addr});
    req_rd    = 1'b0;
    done      = 1'b1;
    cache_hit = 1'b1;
    data_out  = dout;
    step();
    done      = 1'b0;
    cache_hit = 1'b0;
    check_eq("ld_rsp", {bus_a.rsp_valid, bus_a.rsp_data}, {1'b1, dout});
    check_eq("ld_hits", bus_a.hit_cnt, exp_hits);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int last_issue;
    int exp_b[5];
    exp_b = '{1, 2, 3, 3, 3};
    last_issue = 0;

    do_reset();
    check_eq("rst_ctl", {bus_a.Rd, bus_a.Wr, bus_a.rsp_valid, bus_a.err, bus_a.stall_pipe}, 64'h0);
    check_eq("rst_dat", {bus_a.Addr, bus_a.DataIn, bus_a.rsp_data}, 64'h0);
    check_eq("rst_cnt", {bus_a.hit_cnt, bus_a.miss_cnt}, 64'h0);

    // Load hit with 1-cycle Done.
    req_rd   = 1'b1;
    req_addr = 16'h0010;
    #1;
    check_eq("lh_stall_req", bus_a.stall_pipe, 1'b1);
    step();
    check_eq("lh_issue", {bus_a.Rd, bus_a.Wr, bus_a.Addr}, {1'b1, 1'b0, 16'h0010});
    req_rd    = 1'b0;
    done      = 1'b1;
    cache_hit = 1'b1;
    data_out  = 16'hBEEF;
    step();
    done      = 1'b0;
    cache_hit = 1'b0;
    check_eq("lh_rsp", {bus_a.rsp_valid, bus_a.rsp_data}, {1'b1, 16'hBEEF});
    check_eq("lh_hit", {bus_a.hit_cnt, bus_a.miss_cnt}, {16'd1, 16'd0});
    check_eq("lh_stall_rsp", bus_a.stall_pipe, 1'b0);
    check_eq("lh_rd_clr", bus_a.Rd, 1'b0);
    step();
    check_eq("lh_idle", bus_a.rsp_valid, 1'b0);

    // Store miss, Done on the 12th issue cycle.
    req_wr   = 1'b1;
    req_addr = 16'h0200;
    req_data = 16'h1234;
    step();
    req_wr = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      check_eq("sm_stable", {bus_a.Wr, bus_a.Rd, bus_a.Addr, bus_a.DataIn},
               {1'b1, 1'b0, 16'h0200, 16'h1234});
      if (i == 12) begin
        done      = 1'b1;
        cache_hit = 1'b0;
        data_out  = 16'hDEAD;
      end
      step();
    end
    done = 1'b0;
    check_eq("sm_rsp_valid", bus_a.rsp_valid, 1'b1);
    check_eq("sm_cnt", {bus_a.hit_cnt, bus_a.miss_cnt}, {16'd1, 16'd1});
    check_eq("sm_rsp_data", bus_a.rsp_data, 16'hBEEF);
    check_eq("sm_wr_clr", bus_a.Wr, 1'b0);

    // Errors detected in IDLE.
    do_reset();
    req_rd   = 1'b1;
    req_wr   = 1'b1;
    req_addr = 16'h0010;
    step();
    check_eq("both_err", {bus_a.err, bus_a.Rd, bus_a.Wr}, 3'b100);
    clear_inputs();
    step();
    check_eq("both_sticky", {bus_a.err, bus_a.stall_pipe}, 2'b11);

    do_reset();
    req_rd   = 1'b1;
    req_addr = 16'h0003;
    step();
    check_eq("mis_err", {bus_a.err, bus_a.Rd, bus_a.Wr}, 3'b100);
    step();
    check_eq("mis_rd", {bus_a.Rd, bus_a.stall_pipe}, 2'b01);

    do_reset();
    done = 1'b1;
    step();
    done = 1'b0;
    check_eq("spur_done", bus_a.err, 1'b1);

    // Timeout on dut_b (TIMEOUT=8); dut_a keeps waiting.
    do_reset();
    req_rd   = 1'b1;
    req_addr = 16'h0040;
    step();
    req_rd = 1'b0;
    check_eq("to_issue", bus_b.Rd, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      check_eq("to_wait", bus_b.err, 1'b0);
      step();
    end
    check_eq("to_err", {bus_b.err, bus_b.Rd}, 2'b10);
    check_eq("to_a_alive", {bus_a.err, bus_a.Rd}, 2'b01);

    // mem_err together with Done: error wins, no response, counters untouched.
    do_reset();
    req_rd   = 1'b1;
    req_addr = 16'h0080;
    step();
    req_rd = 1'b0;
    step();
    mem_err   = 1'b1;
    done      = 1'b1;
    cache_hit = 1'b1;
    step();
    mem_err   = 1'b0;
    done      = 1'b0;
    cache_hit = 1'b0;
    check_eq("me_err", {bus_a.err, bus_a.rsp_valid, bus_a.Rd}, 3'b100);
    check_eq("me_cnt", {bus_a.hit_cnt, bus_a.miss_cnt}, 64'h0);
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("me_sticky", {bus_a.err, bus_a.stall_pipe, bus_a.rsp_valid}, 3'b110);
    end

    // Reset in the middle of an access.
    do_reset();
    do_load_hit(16'h0020, 16'h5A5A, 16'd1);
    req_rd   = 1'b1;
    req_addr = 16'h0100;
    step();
    req_rd = 1'b0;
    check_eq("mid_pre", bus_a.Rd, 1'b1);
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_ctl", {bus_a.Rd, bus_a.Wr, bus_a.rsp_valid, bus_a.err, bus_a.stall_pipe}, 64'h0);
    check_eq("mid_rst_dat", {bus_a.Addr, bus_a.DataIn, bus_a.rsp_data}, 64'h0);
    check_eq("mid_rst_cnt", {bus_a.hit_cnt, bus_a.miss_cnt}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("mid_norsp", bus_a.rsp_valid, 1'b0);
    end
    rst = 1'b1;
    step();
    check_eq("mid_after", {bus_a.rsp_valid, bus_a.Rd, bus_a.err}, 3'b000);
    do_load_hit(16'h0104, 16'h7777, 16'd1);

    // Back-to-back hits with the request held high: saturation on dut_b, spacing of 3.
    do_reset();
    req_rd   = 1'b1;
    req_addr = 16'h0300;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bb_rd", bus_b.Rd, 1'b1);
      if (i > 0) begin
        check_eq("bb_space", cyc - last_issue, 3);
      end
      last_issue = cyc;
      done      = 1'b1;
      cache_hit = 1'b1;
      data_out  = 16'h0A00 + 16'(i);
      step();
      done      = 1'b0;
      cache_hit = 1'b0;
      check_eq("sat_hit", bus_b.hit_cnt, exp_b[i]);
      check_eq("sat_rsp", {bus_b.rsp_valid, bus_b.rsp_data}, {1'b1, 16'h0A00 + 16'(i)});
      check_eq("bb_a_hit", bus_a.hit_cnt, i + 1);
      step();
      check_eq("bb_idle_stall", {bus_b.stall_pipe, bus_b.rsp_valid}, 2'b10);
    end
    req_rd = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
